// File: rtl/tiny_evg.sv
// ============================================================================
// tiny_evg : 16-bit event generator slot scheduler (comma / seconds / events)
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

module tiny_evg #(
  parameter int unsigned COMMA_INTERVAL = 128,
  parameter string       DEBUG          = "false"
) (
  input  logic                                 evgTxClk,
  (* mark_debug = DEBUG *) input  logic        evgTxReset_n,
  (* mark_debug = DEBUG *) input  logic [7:0]  eventCode,
  (* mark_debug = DEBUG *) input  logic        eventValid,
  (* mark_debug = DEBUG *) output logic        eventReady,
  (* mark_debug = DEBUG *) input  logic        ppsStrobe,
  (* mark_debug = DEBUG *) input  logic [31:0] secondsIn,
  (* mark_debug = DEBUG *) input  logic [7:0]  distributedDataBus,
  (* mark_debug = DEBUG *) output logic [15:0] evgTxWord,
  (* mark_debug = DEBUG *) output logic [1:0]  evgTxCharIsK,
  (* mark_debug = DEBUG *) output logic        sequenceBusy,
  (* mark_debug = DEBUG *) output logic        ppsOverrun
);

  localparam logic [1:0]  c_IDLE  = 2'd0;
  localparam logic [1:0]  c_LOAD  = 2'd1;
  localparam logic [1:0]  c_SHIFT = 2'd2;
  localparam logic [15:0] c_LAST  = 16'(COMMA_INTERVAL - 1);

  // The debug request is carried purely by the port attributes.
  if (DEBUG == "true") begin : g_debug_on
  end

  logic [1:0]  state_q, state_d;
  logic [15:0] slot_cnt_q, slot_cnt_d;
  logic [31:0] secs_q, secs_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic        pending_q, pending_d;
  logic        busy_q, busy_d;
  logic        ovr_q, ovr_d;
  logic [15:0] word_q, word_d;
  logic        k0_q, k0_d;
  logic        alive_q;
  logic        comma_due;
  logic        accept;
  logic [7:0]  byte_d;

  assign comma_due  = (slot_cnt_q == c_LAST);
  // alive_q keeps the handshake closed until the first edge after reset.
  assign eventReady = alive_q && (state_q == c_IDLE) && !comma_due && !pending_q;
  assign accept     = eventValid && eventReady;

  always_comb begin
    state_d    = state_q;
    secs_d     = secs_q;
    bit_cnt_d  = bit_cnt_q;
    pending_d  = pending_q;
    ovr_d      = 1'b0;
    byte_d     = 8'h00;
    k0_d       = 1'b0;
    slot_cnt_d = comma_due ? 16'd0 : slot_cnt_q + 16'd1;

    if (comma_due) begin
      byte_d = 8'hBC;
      k0_d   = 1'b1;
    end else begin
      case (state_q)
        c_LOAD: begin
          byte_d    = 8'h7D;
          pending_d = 1'b0;
          bit_cnt_d = 5'd0;
          state_d   = c_SHIFT;
        end
        c_SHIFT: begin
          byte_d    = secs_q[31] ? 8'h71 : 8'h70;
          secs_d    = {secs_q[30:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 5'd1;
          if (bit_cnt_q == 5'd31) state_d = c_IDLE;
        end
        default: begin
          if (accept) byte_d = eventCode;
        end
      endcase
    end

    // A strobe lets the current slot go out, then (re)starts the sequence.
    if (ppsStrobe) begin
      secs_d    = secondsIn;
      pending_d = 1'b1;
      bit_cnt_d = 5'd0;
      state_d   = c_LOAD;
      ovr_d     = busy_q;
    end

    busy_d = (state_d != c_IDLE);
    word_d = {distributedDataBus, byte_d};
  end

  always_ff @(posedge evgTxClk or negedge evgTxReset_n) begin
    if (!evgTxReset_n) begin
      state_q    <= c_IDLE;
      slot_cnt_q <= 16'd0;
      secs_q     <= 32'd0;
      bit_cnt_q  <= 5'd0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      word_q     <= 16'h00BC;
      k0_q       <= 1'b1;
      alive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      secs_q     <= secs_d;
      bit_cnt_q  <= bit_cnt_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      ovr_q      <= ovr_d;
      word_q     <= word_d;
      k0_q       <= k0_d;
      alive_q    <= 1'b1;
    end
  end

  assign evgTxWord    = word_q;
  assign evgTxCharIsK = {1'b0, k0_q};
  assign sequenceBusy = busy_q;
  assign ppsOverrun   = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_tiny_evg.sv
// Bench for tiny_evg: two instances (comma interval 128 and 4) share one
// stimulus stream and are each compared slot by slot against a byte-level model.
`default_nettype none

module tb_tiny_evg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ev_code;
  logic        ev_valid;
  logic        pps;
  logic [31:0] secs;
  logic [7:0]  dbus;

  logic [1:0]        ready;
  logic [1:0][15:0]  word;
  logic [1:0][1:0]   charisk;
  logic [1:0]        busy;
  logic [1:0]        ovr;

  int n_cmp;
  int n_bad;

  tiny_evg #(.COMMA_INTERVAL(128)) u_dut_a (
    .evgTxClk(clk), .evgTxReset_n(rst_n), .eventCode(ev_code), .eventValid(ev_valid),
    .eventReady(ready[0]), .ppsStrobe(pps), .secondsIn(secs), .distributedDataBus(dbus),
    .evgTxWord(word[0]), .evgTxCharIsK(charisk[0]), .sequenceBusy(busy[0]), .ppsOverrun(ovr[0])
  );

  tiny_evg #(.COMMA_INTERVAL(4)) u_dut_b (
    .evgTxClk(clk), .evgTxReset_n(rst_n), .eventCode(ev_code), .eventValid(ev_valid),
    .eventReady(ready[1]), .ppsStrobe(pps), .secondsIn(secs), .distributedDataBus(dbus),
    .evgTxWord(word[1]), .evgTxCharIsK(charisk[1]), .sequenceBusy(busy[1]), .ppsOverrun(ovr[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: slots since last comma, plus the list of sequence bytes
  // still owed to the wire (position 33 means nothing owed).
  int         m_iv[2] = '{128, 4};
  int         m_cnt[2];
  logic [7:0] m_seq[2][33];
  int         m_pos[2];
  logic       m_rdy_en[2];
  logic       m_acc[2];
  logic [15:0] e_word[2];
  logic [1:0]  e_k[2];
  logic        e_busy[2];
  logic        e_ovr[2];
  int          ovr_seen;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_cnt[k]    = 0;
      m_pos[k]    = 33;
      m_rdy_en[k] = 1'b0;
      m_acc[k]    = 1'b0;
      e_word[k]   = 16'h00BC;
      e_k[k]      = 2'b01;
      e_busy[k]   = 1'b0;
      e_ovr[k]    = 1'b0;
    end
  endtask

  task automatic step(input logic rn, input logic v, input logic [7:0] c,
                      input logic p, input logic [31:0] s, input logic [7:0] b);
    logic rdy;
    logic busy0;
    logic [7:0] byt;
    logic kk;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      rdy = m_rdy_en[k] && (m_cnt[k] != m_iv[k] - 1) && (m_pos[k] == 33);
      chk($sformatf("word%0d", k), 32'(word[k]), 32'(e_word[k]));
      chk($sformatf("isk%0d", k), 32'(charisk[k]), 32'(e_k[k]));
      chk($sformatf("busy%0d", k), 32'(busy[k]), 32'(e_busy[k]));
      chk($sformatf("ovr%0d", k), 32'(ovr[k]), 32'(e_ovr[k]));
      chk($sformatf("ready%0d", k), 32'(ready[k]), 32'(rdy));
    end
    if (ovr[0]) ovr_seen++;
    rst_n = rn; ev_valid = v; ev_code = c; pps = p; secs = s; dbus = b;
    if (!rn) begin
      model_reset();
    end else begin
      for (int k = 0; k < 2; k++) begin
        busy0 = (m_pos[k] < 33);
        rdy   = m_rdy_en[k] && (m_cnt[k] != m_iv[k] - 1) && !busy0;
        m_acc[k] = 1'b0;
        kk = 1'b0;
        if (m_cnt[k] == m_iv[k] - 1) begin
          byt = 8'hBC; kk = 1'b1; m_cnt[k] = 0;
        end else begin
          m_cnt[k]++;
          if (busy0) begin
            byt = m_seq[k][m_pos[k]]; m_pos[k]++;
          end else if (v && rdy) begin
            byt = c; m_acc[k] = 1'b1;
          end else begin
            byt = 8'h00;
          end
        end
        e_ovr[k] = p && busy0;
        if (p) begin
          m_seq[k][0] = 8'h7D;
          for (int i = 0; i < 32; i++) m_seq[k][i+1] = s[31-i] ? 8'h71 : 8'h70;
          m_pos[k] = 0;
        end
        e_busy[k]   = (m_pos[k] < 33);
        e_word[k]   = {b, byt};
        e_k[k]      = {1'b0, kk};
        m_rdy_en[k] = 1'b1;
      end
    end
  endtask

  initial begin
    int cur;
    int guard;
    rst_n = 1'b0; ev_valid = 1'b0; ev_code = 8'h00; pps = 1'b0; secs = 32'd0; dbus = 8'h00;
    n_cmp = 0; n_bad = 0; ovr_seen = 0;
    model_reset();

    repeat (3) step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 8'h00);

    // Idle traffic: commas only.
    repeat (300) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h00);

    // Back-to-back events with valid held until accepted.
    cur = 1; guard = 0;
    while (cur <= 10 && guard < 100) begin
      step(1'b1, 1'b1, 8'(cur), 1'b0, 32'd0, 8'h3C);
      if (m_acc[0]) cur++;
      guard++;
    end
    chk("push_done", 32'(cur), 32'd11);
    step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h00);

    // Seconds sequence.
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'h8000_0001, 8'h00);
    repeat (45) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h00);

    // Overrun: restart after ten bits.
    ovr_seen = 0;
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF, 8'h11);
    repeat (11) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h11);
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'h1234_5678, 8'h22);
    repeat (45) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h22);
    chk("ovr_pulses", 32'(ovr_seen), 32'd1);

    // Reset mid-shift with a live distributed bus.
    step(1'b1, 1'b0, 8'h00, 1'b1, 32'hFFFF_0000, 8'hA5);
    repeat (10) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'hA5);
    repeat (2) step(1'b0, 1'b0, 8'h00, 1'b0, 32'd0, 8'hA5);
    repeat (40) step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'hA5);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 499) != 0), 1'($urandom), 8'($urandom),
           ($urandom_range(0, 59) == 0), $urandom, 8'($urandom));
    end
    step(1'b1, 1'b0, 8'h00, 1'b0, 32'd0, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/tiny_evg.md
TINY_EVG -- requirements
Module: tiny_evg

Interface
REQ-001 Parameter COMMA_INTERVAL, default 128, SHALL set the maximum number of slots between consecutive K28.5 commas; legal range 4..65535.
REQ-002 Parameter DEBUG, default "false", SHALL be applied as mark_debug on all ports except the clock.
REQ-003 evgTxClk  input  1  SHALL be the single clock; one 16-bit slot per cycle.
REQ-004 evgTxReset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 eventCode  input  8  SHALL be the user event code to transmit.
REQ-006 eventValid  input  1  SHALL qualify eventCode.
REQ-007 eventReady  output  1  SHALL indicate the block accepts eventCode this cycle.
REQ-008 ppsStrobe  input  1  SHALL be a one-cycle pulse marking a seconds boundary.
REQ-009 secondsIn  input  32  SHALL be the seconds value to shift out, sampled on ppsStrobe.
REQ-010 distributedDataBus  input  8  SHALL be the distributed bus bits to transmit.
REQ-011 evgTxWord  output  16  SHALL be the transceiver word: [15:8] distributed bus, [7:0] event/K byte.
REQ-012 evgTxCharIsK  output  2  SHALL flag K characters per byte of evgTxWord.
REQ-013 sequenceBusy  output  1  SHALL be high while a seconds sequence is in progress.
REQ-014 ppsOverrun  output  1  SHALL pulse for one cycle when ppsStrobe arrives while sequenceBusy.

Function
REQ-015 All outputs except eventReady SHALL be registered; a slot decided in cycle N SHALL appear on evgTxWord in cycle N+1.
REQ-016 evgTxWord[15:8] SHALL equal distributedDataBus delayed one cycle; evgTxCharIsK[1] SHALL always be 0.
REQ-017 Slot priority, highest first: comma due, 0x7D, seconds bit, user event, null (0x00).
REQ-018 Comma slot SHALL drive [7:0]=0xBC with evgTxCharIsK[0]=1; all other slots SHALL drive evgTxCharIsK[0]=0.
REQ-019 Slot counter SHALL count slots since the last comma and force a comma when it reaches COMMA_INTERVAL-1, then return to 0.
REQ-020 eventReady SHALL be a function of registered state only: high iff state IDLE, comma not due, and no PPS pending.
REQ-021 Handshake: an event is accepted when eventValid and eventReady are high in the same cycle; eventCode SHALL NOT be sampled otherwise; no event SHALL be dropped or duplicated.
REQ-022 State machine: IDLE, LOAD, SHIFT; on ppsStrobe in IDLE, secondsIn SHALL be latched and a PPS pending flag set.
REQ-023 IDLE->LOAD on the first non-comma slot with PPS pending; LOAD SHALL emit 0x7D, clear pending, then go to SHIFT.
REQ-024 SHIFT SHALL emit 32 slots, MSB first, 0x71 for a 1 bit and 0x70 for a 0 bit, then return to IDLE.
REQ-025 A comma due during LOAD or SHIFT SHALL preempt that slot; the pending 0x7D or bit SHALL be sent in the next slot, with bit order preserved.
REQ-026 ppsStrobe in the same cycle as an accepted user event: the event SHALL take that slot and LOAD SHALL begin next slot.
REQ-027 ppsStrobe while sequenceBusy SHALL pulse ppsOverrun, latch the new secondsIn, and restart at LOAD.
REQ-028 sequenceBusy SHALL be high from the cycle after ppsStrobe until the slot after the last seconds bit.

Reset
REQ-029 While evgTxReset_n is low: evgTxWord=16'h00BC, evgTxCharIsK=2'b01, eventReady=0, sequenceBusy=0, ppsOverrun=0, state IDLE, slot counter 0, pending cleared.
REQ-030 Reset asserted mid-sequence SHALL abandon the sequence; after deassertion, the first slot SHALL be normal traffic with no 0x7D and no seconds bits.

Verification
REQ-031 Idle 300 cycles, COMMA_INTERVAL=128 -> 0xBC/K every 128th slot, 0x00/non-K otherwise.
REQ-032 Push events 0x01..0x0A back-to-back, valid held -> each appears exactly once, in order, one cycle after acceptance; stalls only on comma slots.
REQ-033 ppsStrobe with secondsIn=32'h8000_0001 -> 0x7D, 0x71, thirty 0x70, 0x71; sequenceBusy high 33 slots.
REQ-034 COMMA_INTERVAL=4 with PPS -> commas interleave while the 0x7D+32-bit sequence stays complete and in order.
REQ-035 Second ppsStrobe after 10 bits -> ppsOverrun pulses once; the sequence restarts with 0x7D and the new value.
REQ-036 distributedDataBus=0xA5 with reset pulsed mid-SHIFT -> [15:8]=0xA5 one cycle later; reset values hold; no seconds events follow.
